// File: rtl/instr_rom_loader_pkg.sv
// Shared constants and state encoding for the instruction ROM loader.
package instr_rom_loader_pkg;

  localparam int unsigned ROM_ADDR_W      = 8;
  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam logic [31:0] TERMINATOR      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/instr_rom_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit instruction words.
module instr_rom_loader_byte_packer
  import instr_rom_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               take,
  input  logic [7:0]         byte_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_complete
);

  logic [1:0] lane;

  // Lane counter and assembly register; the first byte of a word lands in the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
    end else if (take) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    word[31:24] <= byte_data;
        2'd1:    word[23:16] <= byte_data;
        2'd2:    word[15:8]  <= byte_data;
        default: word[7:0]   <= byte_data;
      endcase
    end
  end

  // Pulses on the handshake that fills the last lane.
  assign word_complete = take && (lane == 2'd3);

endmodule

// File: rtl/instr_rom_loader.sv
// Byte-stream loader for the instruction ROM: packs words, writes them
// sequentially and stops on the all-zero terminator or when memory is full.
module instr_rom_loader
  import instr_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       rom_size,
  output logic              load_done,
  output logic              overflow
);

  loader_state_t     state, state_nxt;
  logic [ADDR_W:0]   count, count_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] word;
  logic              word_complete;
  logic              take, arm, is_term, wr_fire;

  assign take      = byte_valid && byte_ready;
  assign arm       = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign count_inc = count + (ADDR_W+1)'(1);
  assign is_term   = (word == TERMINATOR);
  assign wr_fire   = (state == ST_WRITE) && !is_term;

  instr_rom_loader_byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (arm),
    .take          (take),
    .byte_data     (byte_data),
    .word          (word),
    .word_complete (word_complete)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; memory full is reached when the incremented count hits 2**ADDR_W.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arm) state_nxt = ST_COLLECT;
      ST_COLLECT: if (word_complete) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = (is_term || count_inc[ADDR_W]) ? ST_DONE : ST_COLLECT;
      ST_DONE:    if (arm) state_nxt = ST_COLLECT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Word counter, size/flag registers and the held write address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      rom_size  <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else if (arm) begin
      count     <= '0;
      rom_size  <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == ST_WRITE) begin
      if (is_term) begin
        rom_size  <= 32'({count, 2'b00});
        load_done <= 1'b1;
      end else begin
        count  <= count_inc;
        addr_q <= count[ADDR_W-1:0];
        data_q <= word;
        if (count_inc[ADDR_W]) begin
          rom_size  <= 32'({count_inc, 2'b00});
          overflow  <= 1'b1;
          load_done <= 1'b1;
        end
      end
    end
  end

  // Outputs: the write port shows the live word during the write cycle and the
  // registered copy afterwards, so wr_addr/wr_data hold between strobes.
  always_comb begin
    byte_ready = (state == ST_COLLECT);
    wr_en      = wr_fire;
    wr_addr    = wr_fire ? count[ADDR_W-1:0] : addr_q;
    wr_data    = wr_fire ? word : data_q;
  end

endmodule

// File: tb/tb_instr_rom_loader.sv
// Self-checking bench for instr_rom_loader (small 4-word memory so overflow is reachable).
module tb_instr_rom_loader;

  localparam int unsigned AW  = 2;
  localparam int unsigned CAP = 4;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, wr_en, load_done, overflow;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data, rom_size;

  always #5 clk = ~clk;

  instr_rom_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rom_size   (rom_size),
    .load_done  (load_done),
    .overflow   (overflow)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Behavioural model: a load is either accepting bytes, or spending one cycle
  // committing a finished word; bytes are shifted in, four make a word.
  logic          m_loading, m_pending, m_wr_en, m_done, m_ovf;
  logic [31:0]   m_word, m_wr_data, m_rom_size;
  logic [AW-1:0] m_wr_addr;
  int unsigned   m_nb, m_count;

  // Observed writes, for literal checks per test.
  logic [AW-1:0] log_addr [0:63];
  logic [31:0]   log_data [0:63];
  int unsigned   log_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_pending = 0; m_wr_en = 0; m_done = 0; m_ovf = 0;
    m_word = '0; m_wr_data = '0; m_rom_size = '0; m_wr_addr = '0;
    m_nb = 0; m_count = 0;
  endtask

  task automatic model_step();
    if (m_pending) begin
      m_pending = 0;
      m_wr_en   = 0;
      if (m_word == 32'h0) begin
        m_done = 1; m_loading = 0; m_rom_size = m_count * 4;
      end else begin
        m_count++;
        if (m_count == CAP) begin
          m_done = 1; m_ovf = 1; m_loading = 0; m_rom_size = m_count * 4;
        end
      end
    end else if (m_loading) begin
      if (byte_valid) begin
        m_word = {m_word[23:0], byte_data};
        m_nb++;
        if (m_nb == 4) begin
          m_nb = 0;
          m_pending = 1;
          if (m_word != 32'h0) begin
            m_wr_en = 1; m_wr_addr = AW'(m_count); m_wr_data = m_word;
          end
        end
      end
    end else if (start) begin
      m_loading = 1; m_count = 0; m_nb = 0;
      m_rom_size = '0; m_done = 0; m_ovf = 0;
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("byte_ready", byte_ready, m_loading && !m_pending);
      chk("wr_en", wr_en, m_wr_en);
      chk("wr_addr", wr_addr, m_wr_addr);
      chk("wr_data", wr_data, m_wr_data);
      chk("rom_size", rom_size, m_rom_size);
      chk("load_done", load_done, m_done);
      chk("overflow", overflow, m_ovf);
      if (wr_en === 1'b1 && log_n < 64) begin
        log_addr[log_n] = wr_addr;
        log_data[log_n] = wr_data;
        log_n++;
      end
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      k++;
      if (k > 20) begin
        chk("ready_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_byte_bubbly(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    send_byte(b);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (load_done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", load_done, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned base;
    logic [7:0] t4 [0:7];
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    model_reset();
    fork
      compare_loop();
      model_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", byte_ready, 1'b0);
    chk("reset_size", rom_size, 32'd0);
    @(posedge clk); #1;

    // 1: two instructions then terminator
    base = log_n;
    pulse_start();
    send_word(32'h00500093);
    send_word(32'h00100113);
    send_word(32'h00000000);
    wait_done();
    chk("t1_writes", log_n - base, 32'd2);
    chk("t1_addr0", 32'(log_addr[base]), 32'd0);
    chk("t1_data0", log_data[base], 32'h00500093);
    chk("t1_addr1", 32'(log_addr[base+1]), 32'd1);
    chk("t1_data1", log_data[base+1], 32'h00100113);
    chk("t1_size", rom_size, 32'd8);
    chk("t1_ovf", overflow, 1'b0);

    // 2: immediate terminator
    base = log_n;
    pulse_start();
    send_word(32'h00000000);
    wait_done();
    chk("t2_writes", log_n - base, 32'd0);
    chk("t2_size", rom_size, 32'd0);
    chk("t2_done", load_done, 1'b1);

    // 3: fill memory without terminator; the fifth word is refused
    base = log_n;
    pulse_start();
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    send_word(32'h0D0E0F10);
    wait_done();
    byte_valid = 1'b1; byte_data = 8'h11;
    repeat (8) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("t3_writes", log_n - base, 32'd4);
    chk("t3_addr3", 32'(log_addr[base+3]), 32'd3);
    chk("t3_data3", log_data[base+3], 32'h0D0E0F10);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_size", rom_size, 32'd16);
    chk("t3_ready", byte_ready, 1'b0);

    // 4: bubbles on byte_valid, zero bytes inside a nonzero word
    base = log_n;
    t4[0] = 8'h12; t4[1] = 8'h00; t4[2] = 8'h34; t4[3] = 8'h00;
    t4[4] = 8'h00; t4[5] = 8'h00; t4[6] = 8'h00; t4[7] = 8'h00;
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte_bubbly(t4[i]);
    wait_done();
    chk("t4_writes", log_n - base, 32'd1);
    chk("t4_data", log_data[base], 32'h12003400);
    chk("t4_size", rom_size, 32'd4);

    // 5: reset in the middle of a load discards the partial word
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_done", load_done, 1'b0);
    chk("t5_rst_ready", byte_ready, 1'b0);
    @(posedge clk); #1;
    base = log_n;
    pulse_start();
    send_word(32'hAABBCCDD);
    send_word(32'h00000000);
    wait_done();
    chk("t5_writes", log_n - base, 32'd1);
    chk("t5_addr0", 32'(log_addr[base]), 32'd0);
    chk("t5_data0", log_data[base], 32'hAABBCCDD);
    chk("t5_size", rom_size, 32'd4);

    // 6: reload from DONE; a start mid-word changes nothing
    base = log_n;
    pulse_start();
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    pulse_start();
    send_byte(8'h77);
    send_byte(8'h88);
    send_word(32'h99AABBCC);
    send_word(32'h00000000);
    wait_done();
    chk("t6_writes", log_n - base, 32'd3);
    chk("t6_addr0", 32'(log_addr[base]), 32'd0);
    chk("t6_data1", log_data[base+1], 32'h55667788);
    chk("t6_addr2", 32'(log_addr[base+2]), 32'd2);
    chk("t6_data2", log_data[base+2], 32'h99AABBCC);
    chk("t6_size", rom_size, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
